// File: rtl/iq_sample_player.sv
// I/Q sample FIFO and playout engine on a 4-word wishbone page: the host pushes packed
// I/Q words, and one word is popped and presented per programmable sample period.
module iq_sample_player #(
    parameter int sine_lookup_width = 16,
    parameter int LGFIFO            = 5,
    parameter int RATE_WIDTH        = 16
) (
    input  logic                                i_clk,
    input  logic                                i_resetb,
    input  logic                                i_wb_cyc,
    input  logic                                i_wb_stb,
    input  logic                                i_wb_we,
    input  logic [1:0]                          i_wb_addr,
    input  logic [31:0]                         i_wb_data,
    output logic                                o_wb_ack,
    output logic                                o_wb_stall,
    output logic [31:0]                         o_wb_data,
    output logic signed [sine_lookup_width-1:0] o_signal_i,
    output logic signed [sine_lookup_width-1:0] o_signal_q,
    output logic                                o_sample_stb
);

    localparam int                DEPTH      = 1 << LGFIFO;
    localparam logic [LGFIFO:0]   FULL_COUNT = (LGFIFO + 1)'(DEPTH);
    localparam logic [LGFIFO:0]   ONE_COUNT  = (LGFIFO + 1)'(1);
    localparam logic [LGFIFO-1:0] ONE_PTR    = LGFIFO'(1);

    logic [31:0]           mem [DEPTH];
    logic [LGFIFO-1:0]     wr_ptr, rd_ptr;
    logic [LGFIFO:0]       fill_count;
    logic                  enable;
    logic [RATE_WIDTH-1:0] rate, counter;
    logic                  underflow, overflow;
    logic [31:0]           head_word, rd_data;

    logic bus_req, bus_wr, wr_ctrl, wr_rate, wr_data, wr_status;
    logic flush, tick, fifo_empty, fifo_full, pop, push, uf_set, of_set;

    // Bus handshake: the slave never stalls; every cycle with cyc&stb is accepted and
    // answered by exactly one ack on the following clock, carrying that access's read data.
    assign o_wb_stall = 1'b0;
    assign bus_req    = i_wb_stb && i_wb_cyc;
    assign bus_wr     = bus_req && i_wb_we;
    assign wr_ctrl    = bus_wr && (i_wb_addr == 2'd0);
    assign wr_rate    = bus_wr && (i_wb_addr == 2'd1);
    assign wr_data    = bus_wr && (i_wb_addr == 2'd2);
    assign wr_status  = bus_wr && (i_wb_addr == 2'd3);

    assign flush      = wr_ctrl && i_wb_data[1];
    assign tick       = enable && (counter == '0);
    assign fifo_empty = (fill_count == '0);
    assign fifo_full  = (fill_count == FULL_COUNT);
    assign pop        = tick && !fifo_empty && !flush;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign push       = wr_data && (!fifo_full || pop);
    assign uf_set     = tick && fifo_empty;
    assign of_set     = wr_data && !push;
    assign head_word  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= i_wb_data;
    end

    always_comb begin
        rd_data = '0;
        case (i_wb_addr)
            2'd0: rd_data[0] = enable;
            2'd1: rd_data = 32'(rate);
            2'd3: begin
                rd_data[31]       = underflow;
                rd_data[30]       = overflow;
                rd_data[LGFIFO:0] = fill_count;
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_count   <= '0;
            enable       <= 1'b0;
            rate         <= '0;
            counter      <= '0;
            underflow    <= 1'b0;
            overflow     <= 1'b0;
            o_signal_i   <= '0;
            o_signal_q   <= '0;
            o_sample_stb <= 1'b0;
            o_wb_ack     <= 1'b0;
            o_wb_data    <= '0;
        end else begin
            o_wb_ack  <= bus_req;
            o_wb_data <= bus_req ? rd_data : 32'd0;

            if (wr_ctrl)
                enable <= i_wb_data[0];
            if (wr_rate)
                rate <= i_wb_data[RATE_WIDTH-1:0];

            // Disabled: park the counter on RATE so enabling starts a full period.
            if (!enable || counter == '0)
                counter <= rate;
            else
                counter <= counter - 1'b1;

            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_count <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + ONE_PTR;
                if (pop)
                    rd_ptr <= rd_ptr + ONE_PTR;
                if (push && !pop)
                    fill_count <= fill_count + ONE_COUNT;
                else if (pop && !push)
                    fill_count <= fill_count - ONE_COUNT;
            end

            // Sticky flags: a set event in the same cycle beats the W1C clear.
            if (uf_set)
                underflow <= 1'b1;
            else if (wr_status && i_wb_data[31])
                underflow <= 1'b0;
            if (of_set)
                overflow <= 1'b1;
            else if (wr_status && i_wb_data[30])
                overflow <= 1'b0;

            o_sample_stb <= pop;
            if (pop) begin
                o_signal_i <= head_word[31 -: sine_lookup_width];
                o_signal_q <= head_word[15 -: sine_lookup_width];
            end
        end
    end

endmodule
